// File: rtl/median_job_sched.sv
// median_job_sched: round-robin scheduler that buffers one job per grant and replays it to a shared median engine
module median_job_sched #(
   parameter int W       = 8,
   parameter int N       = 9,
   parameter int R       = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [R-1:0]         req_valid,
   input  logic [R*W-1:0]       req_data,
   output logic [R-1:0]         req_ready,
   output logic                 res_valid,
   output logic [$clog2(R)-1:0] res_id,
   output logic [W-1:0]         res_data,
   output logic                 res_err,
   output logic                 busy,
   output logic                 eng_in_valid,
   output logic [W-1:0]         eng_in,
   input  logic                 eng_in_ready,
   input  logic                 eng_out_ready,
   input  logic [W-1:0]         eng_out
);
   localparam int IDW = $clog2(R);
   localparam int CW  = $clog2(N + 1);
   localparam int AW  = $clog2(N);
   localparam int TW  = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, COLLECT, WAIT_ENG, FEED, WAIT_RES, RESP} state_t;
   state_t         state;
   logic [IDW-1:0] rr_ptr, gnt, pick, cand;
   logic           found, take;
   logic [CW-1:0]  cnt;
   logic [TW-1:0]  tcnt;
   logic [W-1:0]   mem [N];
   assign busy = state != IDLE;
   assign take = state == COLLECT && req_valid[gnt];
   // first requester with valid at or after rr_ptr, wrapping; lowest offset wins
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = R - 1; k >= 0; k--) begin
         cand = IDW'((int'(rr_ptr) + k) % R);
         if (req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end
   // store each accepted sample in arrival order
   always_ff @(posedge clk)
      if (take) mem[cnt[AW-1:0]] <= req_data[gnt*W +: W];
   // job sequencing: collect, wait for engine, feed burst, await result, respond
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         gnt          <= '0;
         cnt          <= '0;
         tcnt         <= '0;
         req_ready    <= '0;
         res_valid    <= 1'b0;
         res_id       <= '0;
         res_data     <= '0;
         res_err      <= 1'b0;
         eng_in_valid <= 1'b0;
         eng_in       <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               gnt       <= pick;
               req_ready <= R'(1) << pick;
               cnt       <= '0;
               state     <= COLLECT;
            end
            COLLECT: if (take) begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) begin
                  req_ready <= '0;
                  state     <= WAIT_ENG;
               end
            end
            WAIT_ENG: if (eng_in_ready) begin
               eng_in_valid <= 1'b1;
               eng_in       <= mem[0];
               cnt          <= CW'(1);
               state        <= FEED;
            end
            FEED: if (cnt == CW'(N)) begin
               eng_in_valid <= 1'b0;
               eng_in       <= '0;
               tcnt         <= '0;
               state        <= WAIT_RES;
            end else begin
               eng_in <= mem[cnt[AW-1:0]];
               cnt    <= cnt + CW'(1);
            end
            WAIT_RES: if (eng_out_ready || tcnt == TW'(TIMEOUT - 1)) begin
               res_valid <= 1'b1;
               res_id    <= gnt;
               res_data  <= eng_out_ready ? eng_out : '0;
               res_err   <= !eng_out_ready;
               state     <= RESP;
            end else tcnt <= tcnt + TW'(1);
            RESP: begin
               res_valid <= 1'b0;
               res_id    <= '0;
               res_data  <= '0;
               res_err   <= 1'b0;
               rr_ptr    <= IDW'((int'(gnt) + 1) % R);
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
